// File: rtl/ov7670_cfg_seq.sv
// ov7670_cfg_seq: walks a {reg,value} init table and feeds SCCB write bytes to a byte-level I2C engine.
// Optional macro OV7670_CFG_DELAY_CMD_EN turns reg 8'hFF entries into value-millisecond waits.
module ov7670_cfg_seq #(
  parameter int         TABLE_LEN     = 87,
  parameter int         ADDR_W        = 7,
  parameter logic [7:0] DEV_ADDR      = 8'h42,
  parameter int         POWERUP_TICKS = 6000000,
  parameter int         GAP_TICKS     = 500,
  parameter int         MAX_RETRY     = 3
)(
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              byte_valid,
  output logic [7:0]        byte_data,
  output logic              byte_first,
  output logic              byte_last,
  input  logic              byte_ready,
  input  logic              byte_done,
  input  logic              byte_nack,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W-1:0] err_addr
);
  typedef enum logic [3:0] {IDLE, POWERUP, FETCH, SEND_ID, SEND_REG, SEND_VAL, GAP, DELAY, DONE, ERROR} state_t;
  localparam logic [ADDR_W-1:0] LAST      = ADDR_W'(TABLE_LEN - 1);
  localparam logic [31:0]       PU_LOAD   = 32'(POWERUP_TICKS - 1);
  localparam logic [31:0]       GAP_LOAD  = 32'(GAP_TICKS - 1);
  localparam logic [7:0]        RETRY_MAX = 8'(MAX_RETRY);
  state_t            r_state, w_state;
  logic [31:0]       r_cnt, w_cnt;
  logic [ADDR_W-1:0] r_addr, w_addr, r_err, w_err;
  logic [7:0]        r_retry, w_retry, r_reg, w_reg, r_val, w_val;
  logic              r_wait, w_wait, r_last, w_last, w_adv, w_send;
  assign w_send     = r_state inside {SEND_ID, SEND_REG, SEND_VAL};
  assign byte_valid = w_send && !r_wait;
  assign byte_first = byte_valid && r_state == SEND_ID;
  assign byte_last  = byte_valid && r_state == SEND_VAL;
  assign byte_data  = r_state == SEND_ID ? DEV_ADDR : r_state == SEND_REG ? r_reg : r_state == SEND_VAL ? r_val : 8'h00;
  assign busy       = !(r_state inside {IDLE, DONE, ERROR});
  assign done       = r_state == DONE;
  assign error      = r_state == ERROR;
  assign rom_addr   = r_addr;
  assign err_addr   = r_err;
  always_comb begin
    w_state = r_state;
    w_cnt   = r_cnt;
    w_addr  = r_addr;
    w_retry = r_retry;
    w_wait  = r_wait;
    w_last  = r_last;
    w_reg   = r_reg;
    w_val   = r_val;
    w_err   = r_err;
    w_adv   = 1'b0;
    case (r_state)
      IDLE, DONE, ERROR: if (start) begin
        w_state = POWERUP;
        w_cnt   = PU_LOAD;
        w_addr  = '0;
        w_retry = '0;
        w_last  = 1'b0;
      end
      POWERUP: if (r_cnt == '0) w_state = FETCH; else w_cnt = r_cnt - 32'd1;
      GAP:     if (r_cnt == '0) w_state = r_last ? DONE : FETCH; else w_cnt = r_cnt - 32'd1;
      DELAY:   if (r_cnt == '0) w_adv = 1'b1; else w_cnt = r_cnt - 32'd1;
      FETCH: begin
        w_reg   = rom_data[15:8];
        w_val   = rom_data[7:0];
        w_state = SEND_ID;
`ifdef OV7670_CFG_DELAY_CMD_EN
        if (rom_data[15:8] == 8'hFF) begin
          w_state = DELAY;
          w_cnt   = 32'(rom_data[7:0]) * 32'd50000 - 32'd1;
          w_adv   = rom_data[7:0] == 8'h00;
        end
`endif
      end
      SEND_ID, SEND_REG, SEND_VAL: begin
        if (!r_wait) w_wait = byte_ready;
        else if (byte_done) begin
          w_wait = 1'b0;
          if (byte_nack && r_retry < RETRY_MAX) begin
            w_retry = r_retry + 8'd1;
            w_cnt   = GAP_LOAD;
            w_state = GAP;
          end else if (byte_nack) begin
            w_err   = r_addr;
            w_state = ERROR;
          end else if (r_state == SEND_VAL) w_adv = 1'b1;
          else w_state = r_state == SEND_ID ? SEND_REG : SEND_VAL;
        end
      end
      default: w_state = IDLE;
    endcase
    // Entry complete: the final entry parks rom_addr and flags the next GAP to finish.
    if (w_adv) begin
      w_state = GAP;
      w_cnt   = GAP_LOAD;
      w_retry = '0;
      w_last  = r_addr == LAST;
      w_addr  = r_addr == LAST ? r_addr : r_addr + ADDR_W'(1);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_err   <= '0;
      r_retry <= '0;
      r_reg   <= '0;
      r_val   <= '0;
      r_wait  <= 1'b0;
      r_last  <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cnt   <= w_cnt;
      r_addr  <= w_addr;
      r_err   <= w_err;
      r_retry <= w_retry;
      r_reg   <= w_reg;
      r_val   <= w_val;
      r_wait  <= w_wait;
      r_last  <= w_last;
    end
  end
endmodule

// File: tb/tb_ov7670_cfg_seq.sv
// tb_ov7670_cfg_seq: randomized engine model plus per-entry reference of the expected SCCB byte stream.
module tb_ov7670_cfg_seq;
  localparam int LEN = 4, AW = 3, PU = 10, GP = 4, MR = 3, LIM = 200000;
  typedef struct packed {logic [7:0] d; logic f; logic l; logic n;} xb_t;
  logic clk = 1'b0, reset, start, byte_valid, byte_first, byte_last, byte_ready, byte_done, byte_nack, busy, done, error;
  logic [AW-1:0] rom_addr, err_addr;
  logic [15:0] rom_data;
  logic [7:0] byte_data;
  logic [15:0] rom [8];
  xb_t exp_q[$], got_q[$];
  int nn[LEN], np[LEN];
  int vec = 0, errs = 0, k = 0, lat_lo = 1, lat_hi = 1, stall_k = -1, stall_n = 0, exp_ea = 0;
  bit rdy_rand = 0, exp_err = 0;

  assign rom_data = rom[rom_addr];
  always #5 clk = ~clk;

  ov7670_cfg_seq #(.TABLE_LEN(LEN), .ADDR_W(AW), .DEV_ADDR(8'h42), .POWERUP_TICKS(PU),
    .GAP_TICKS(GP), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .start(start), .rom_addr(rom_addr), .rom_data(rom_data),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_first(byte_first), .byte_last(byte_last),
    .byte_ready(byte_ready), .byte_done(byte_done), .byte_nack(byte_nack), .busy(busy),
    .done(done), .error(error), .err_addr(err_addr));

  // I2C engine model: all inputs change on the falling edge; the NACK plan comes from the reference stream.
  initial begin
    int dly;
    bit pn;
    dly = 0; pn = 0; byte_ready = 0; byte_done = 0; byte_nack = 0;
    forever begin
      @(negedge clk);
      byte_done = 0; byte_nack = 0;
      if (reset) dly = 0;
      else if (dly > 0) begin
        dly--;
        if (dly == 0) begin byte_done = 1; byte_nack = pn; end
      end else if (byte_valid) begin
        if (k == stall_k && stall_n > 0) begin byte_ready = 0; stall_n--; end
        else byte_ready = rdy_rand ? ($urandom_range(0, 2) != 0) : 1'b1;
        if (byte_ready) begin
          got_q.push_back('{byte_data, byte_first, byte_last, 1'b0});
          pn = k < exp_q.size() ? exp_q[k].n : 1'b0;
          k++;
          dly = $urandom_range(lat_lo, lat_hi);
        end
      end
    end
  end

  task automatic build_exp();
    exp_q.delete(); exp_err = 0; exp_ea = 0;
    for (int e = 0; e < LEN && !exp_err; e++) begin
      int a = 0;
      bit ok = 0;
`ifdef OV7670_CFG_DELAY_CMD_EN
      if (rom[e][15:8] == 8'hFF) ok = 1;
`endif
      while (!ok && !exp_err) begin
        bit nk = 0;
        for (int b = 0; b < 3 && !nk; b++) begin
          logic [7:0] d;
          d = b == 0 ? 8'h42 : b == 1 ? rom[e][15:8] : rom[e][7:0];
          nk = a < nn[e] && b == np[e];
          exp_q.push_back('{d, b == 0, b == 2, nk});
        end
        if (!nk) ok = 1;
        else if (++a > MR) begin exp_err = 1; exp_ea = e; end
      end
    end
  endtask

  function automatic int stream_diffs();
    int d = got_q.size() > exp_q.size() ? got_q.size() - exp_q.size() : exp_q.size() - got_q.size();
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if ({got_q[i].d, got_q[i].f, got_q[i].l} !== {exp_q[i].d, exp_q[i].f, exp_q[i].l}) d++;
    return d;
  endfunction

  function automatic int firsts();
    int c = 0;
    foreach (got_q[i]) if (got_q[i].f) c++;
    return c;
  endfunction

  task automatic run_seq(input bit extra, output int cyc, output int lat);
    k = 0; got_q.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    cyc = 0; lat = -1;
    while (!(done || error) && cyc < LIM) begin
      if (lat < 0 && byte_valid) lat = cyc;
      @(negedge clk);
      cyc++;
      start = extra && cyc == 30;
    end
    start = 0;
    vec++;
    if (cyc >= LIM) begin errs++; $display("FAIL run_timeout cycles=%0d limit=%0d", cyc, LIM); end
  endtask

  task automatic set_basic();
    rom[0] = 16'h1280; rom[1] = 16'h1101; rom[2] = 16'h2A3C; rom[3] = 16'h0A55;
    foreach (nn[e]) begin nn[e] = 0; np[e] = 0; end
    rdy_rand = 0; lat_lo = 1; lat_hi = 1;
  endtask

  task automatic test_reset();
    reset = 1; start = 0;
    repeat (3) @(negedge clk);
    vec++;
    if ({byte_valid, byte_first, byte_last, busy, done, error, rom_addr, err_addr, byte_data} !== '0) begin
      errs++; $display("FAIL reset_outputs got %h want 0", {byte_valid, byte_first, byte_last, busy, done, error, rom_addr, err_addr, byte_data});
    end
    reset = 0;
    @(negedge clk);
    vec++;
    if (busy !== 1'b0) begin errs++; $display("FAIL reset_idle busy=%b want 0", busy); end
  endtask

  task automatic test_basic();
    int cyc, lat;
    set_basic(); build_exp();
    run_seq(0, cyc, lat);
    vec++; if (lat !== PU + 1) begin errs++; $display("FAIL basic_latency got %0d want %0d", lat, PU + 1); end
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL basic_stream diffs=%0d got %0d bytes want %0d", stream_diffs(), got_q.size(), exp_q.size()); end
    vec++; if ({done, busy, error} !== 3'b100) begin errs++; $display("FAIL basic_status got %b want 100", {done, busy, error}); end
    vec++; if (rom_addr !== AW'(LEN - 1)) begin errs++; $display("FAIL basic_addr_nowrap got %0d want %0d", rom_addr, LEN - 1); end
  endtask

  task automatic test_stall();
    int cyc, lat, bad, n12;
    bit hit;
    set_basic(); build_exp();
    stall_k = 1; stall_n = 7; bad = 0; hit = 0;
    fork
      run_seq(0, cyc, lat);
      begin
        for (int i = 0; i < 200 && !hit; i++) begin
          @(negedge clk);
          hit = byte_valid && byte_data == 8'h12;
        end
        for (int i = 0; i < 7; i++) begin
          @(negedge clk);
          if (!(byte_valid === 1'b1 && byte_data === 8'h12)) bad++;
        end
      end
    join
    stall_k = -1;
    n12 = 0;
    foreach (got_q[i]) if (got_q[i].d == 8'h12) n12++;
    vec++; if (!hit || bad !== 0) begin errs++; $display("FAIL stall_hold seen=%0d unstable_cycles=%0d want 1/0", hit, bad); end
    vec++; if (n12 !== 1) begin errs++; $display("FAIL stall_single_transfer got %0d want 1", n12); end
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL stall_stream diffs=%0d want 0", stream_diffs()); end
  endtask

  task automatic test_nack_retry();
    int cyc, lat;
    set_basic(); nn[0] = 1; np[0] = 2; build_exp();
    run_seq(0, cyc, lat);
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL nack_stream diffs=%0d want 0", stream_diffs()); end
    vec++; if (firsts() !== LEN + 1) begin errs++; $display("FAIL nack_attempts got %0d want %0d", firsts(), LEN + 1); end
    vec++; if (done !== 1'b1) begin errs++; $display("FAIL nack_done got %b want 1", done); end
  endtask

  task automatic test_error();
    int cyc, lat;
    set_basic(); nn[1] = 99; np[1] = $urandom_range(0, 2); build_exp();
    run_seq(0, cyc, lat);
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL err_stream diffs=%0d want 0", stream_diffs()); end
    vec++; if (firsts() !== 1 + MR + 1) begin errs++; $display("FAIL err_attempts got %0d want %0d", firsts(), MR + 2); end
    vec++; if ({error, done, busy} !== 3'b100) begin errs++; $display("FAIL err_status got %b want 100", {error, done, busy}); end
    vec++; if (err_addr !== AW'(1)) begin errs++; $display("FAIL err_addr got %0d want 1", err_addr); end
    nn[1] = 0; build_exp();
    run_seq(0, cyc, lat);
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL err_restart_stream diffs=%0d want 0", stream_diffs()); end
    vec++; if ({done, error} !== 2'b10) begin errs++; $display("FAIL err_restart_status got %b want 10", {done, error}); end
  endtask

  task automatic test_back_to_back();
    int cyc, lat;
    set_basic(); rdy_rand = 1; lat_hi = 3; build_exp();
    run_seq(1, cyc, lat);
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL b2b_busy_start diffs=%0d want 0", stream_diffs()); end
    run_seq(0, cyc, lat);
    vec++; if (stream_diffs() !== 0 || done !== 1'b1) begin errs++; $display("FAIL b2b_from_done diffs=%0d done=%b want 0/1", stream_diffs(), done); end
  endtask

  task automatic test_reset_mid();
    bit hit = 0;
    set_basic(); build_exp(); k = 0; got_q.delete();
    @(negedge clk); start = 1;
    @(negedge clk); start = 0;
    for (int i = 0; i < 2000 && !hit; i++) begin
      @(negedge clk);
      hit = byte_valid && rom_addr == AW'(2) && !byte_first && !byte_last;
    end
    vec++; if (!hit) begin errs++; $display("FAIL rstmid_reach_send_reg got 0 want 1"); end
    reset = 1;
    @(negedge clk);
    vec++;
    if ({byte_valid, rom_addr, busy, done, error} !== '0) begin
      errs++; $display("FAIL rstmid_state got valid=%b addr=%0d busy=%b done=%b err=%b want all 0", byte_valid, rom_addr, busy, done, error);
    end
    reset = 0;
    repeat (5) @(negedge clk);
  endtask

  task automatic test_random();
    int cyc, lat;
    for (int it = 0; it < 8; it++) begin
      for (int e = 0; e < LEN; e++) begin
        rom[e] = {8'($urandom_range(0, 254)), 8'($urandom_range(0, 255))};
        nn[e] = $urandom_range(0, 3) == 0 ? $urandom_range(1, 4) : 0;
        np[e] = $urandom_range(0, 2);
      end
      rdy_rand = 1; lat_lo = 1; lat_hi = 4;
      build_exp();
      run_seq(0, cyc, lat);
      vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL rand%0d_stream diffs=%0d want 0", it, stream_diffs()); end
      vec++; if ({error, done} !== {exp_err, !exp_err}) begin errs++; $display("FAIL rand%0d_status got %b want %b", it, {error, done}, {exp_err, !exp_err}); end
      vec++;
      if (exp_err ? err_addr !== AW'(exp_ea) : rom_addr !== AW'(LEN - 1)) begin
        errs++; $display("FAIL rand%0d_addr err_addr=%0d rom_addr=%0d want %0d", it, err_addr, rom_addr, exp_err ? exp_ea : LEN - 1);
      end
    end
  endtask

  task automatic test_delay();
    int cyc, lat;
    set_basic(); rom[0] = 16'hFF02; rom[1] = 16'h1101; build_exp();
    run_seq(0, cyc, lat);
    vec++; if (stream_diffs() !== 0) begin errs++; $display("FAIL delay_stream diffs=%0d want 0", stream_diffs()); end
`ifdef OV7670_CFG_DELAY_CMD_EN
    vec++; if (lat !== PU + 1 + 1 + 2 * 50000 + GP) begin errs++; $display("FAIL delay_wait got %0d want %0d", lat, PU + 2 + 100000 + GP); end
`else
    vec++; if (got_q.size() < 2 || got_q[1].d !== 8'hFF) begin errs++; $display("FAIL ff_sent_plain got %0d bytes want reg FF sent", got_q.size()); end
`endif
  endtask

  initial begin
    foreach (rom[i]) rom[i] = '0;
    test_reset();
    test_basic();
    test_stall();
    test_nack_retry();
    test_error();
    test_back_to_back();
    test_reset_mid();
    test_random();
    test_delay();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
